// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control -- multi-cycle main control unit for the MIPS core.
//
// Steps each instruction through FETCH / DECODE / execute / memory /
// writeback states and drives the datapath enables and mux selects for the
// current state. The memory states wait on mem_ready, and a bounded wait
// counter traps a stalled access. Unknown opcodes also trap. TRAP is sticky
// until reset.
//
// Parameters:
//   MAX_WAIT  consecutive mem_ready-low cycles tolerated before trapping
//             (0 disables the timeout)
//   ALUOPW    width of aluop (>= 4, upper bits driven 0)
//
// Optional feature macro: MC_CONTROL_RETIRE_CNT_EN
//   defined   -> retired counts transitions back into FETCH (wraps at 2^32)
//   undefined -> retired is tied to 0
//
// Ports:
//   clk, reset               rising-edge clock, async active-high reset
//   op, funct, rt            instruction fields from the IR
//   mem_ready                memory completes the current access this cycle
//   alu_zero, alu_neg        ALU result flags for branch resolution
//   pc_en, iord, mem_read, mem_write, ir_write, regwrite   datapath enables
//   regdest, memtoreg, alusrc_a, alusrc_b, aluop, pcsrc    datapath muxes
//   state                    current state (debug)
//   trap                     sticky fault flag
//   retired                  retired-instruction count
// ---------------------------------------------------------------------------
module mc_control #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned ALUOPW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic [4:0]        rt,
    input  logic              mem_ready,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              pc_en,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic [1:0]        regdest,
    output logic [1:0]        memtoreg,
    output logic              regwrite,
    output logic              alusrc_a,
    output logic [1:0]        alusrc_b,
    output logic [ALUOPW-1:0] aluop,
    output logic [1:0]        pcsrc,
    output logic [3:0]        state,
    output logic              trap,
    output logic [31:0]       retired
);

    localparam int unsigned WW = (MAX_WAIT > 32'd0) ? $clog2(MAX_WAIT + 32'd1) : 1;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FN_JR     = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [WW-1:0] r_wait;
    logic          w_waiting;
    logic          w_timeout;
    logic          w_taken;

    logic          w_pc_en, w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic          w_regwrite, w_alusrc_a;
    logic [1:0]    w_regdest, w_memtoreg, w_alusrc_b, w_pcsrc;
    logic [3:0]    w_aluop;

    // A wait cycle is a memory-access state whose access has not completed.
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                       && !mem_ready;
    assign w_timeout = w_waiting && (MAX_WAIT != 32'd0) && (r_wait == WW'(MAX_WAIT));

    // Branch resolution from the ALU flags of rs - rt (or rs for single-operand forms).
    always_comb begin
        case (op)
            OP_BEQ:    w_taken = alu_zero;
            OP_BNE:    w_taken = !alu_zero;
            OP_BLEZ:   w_taken = alu_neg || alu_zero;
            OP_BGTZ:   w_taken = !alu_neg && !alu_zero;
            OP_REGIMM: w_taken = (rt == 5'd0) ? alu_neg : !alu_neg;
            default:   w_taken = 1'b0;
        endcase
    end

    // Next-state logic, including decode dispatch and wait timeouts.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
                else                w_next = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                      w_next = S_MEMADR;
                    OP_RTYPE:                          w_next = (funct == FN_JR) ? S_JR : S_RTYPE_EX;
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
                    OP_REGIMM:                         w_next = S_BRANCH;
                    OP_J:                              w_next = S_JUMP;
                    OP_JAL:                            w_next = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI:          w_next = S_IMM_EX;
                    default:                           w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
                else                w_next = S_MEMRD;
            end
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
                else                w_next = S_MEMWR;
            end
            S_RTYPE_EX: w_next = S_RTYPE_WB;
            S_RTYPE_WB: w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_IMM_EX:   w_next = S_IMM_WB;
            S_IMM_WB:   w_next = S_FETCH;
            S_JAL:      w_next = S_FETCH;
            S_JR:       w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            // The unused encoding is treated as a fault.
            default:    w_next = S_TRAP;
        endcase
    end

    // State register and wait counter; the counter restarts on every completed
    // access and every state change, and saturates rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (mem_ready || (w_next != r_state)) begin
                r_wait <= '0;
            end else if (w_waiting && (r_wait != {WW{1'b1}})) begin
                r_wait <= r_wait + WW'(1);
            end else begin
                r_wait <= r_wait;
            end
        end
    end

    // Datapath control decode for the current state.
    always_comb begin
        w_pc_en     = 1'b0;
        w_iord      = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_regwrite  = 1'b0;
        w_alusrc_a  = 1'b0;
        w_regdest   = 2'b00;
        w_memtoreg  = 2'b00;
        w_alusrc_b  = 2'b00;
        w_pcsrc     = 2'b00;
        w_aluop     = 4'b0000;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_alusrc_b = 2'b01;
                w_pc_en    = mem_ready;
                w_ir_write = mem_ready;
            end
            // Precompute the branch target into ALUOut.
            S_DECODE:   w_alusrc_b = 2'b11;
            S_MEMADR: begin
                w_alusrc_a = 1'b1;
                w_alusrc_b = 2'b10;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 2'b01;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                w_alusrc_a = 1'b1;
                w_aluop    = 4'b0110;
            end
            S_RTYPE_WB: begin
                w_regwrite = 1'b1;
                w_regdest  = 2'b01;
            end
            S_BRANCH: begin
                w_alusrc_a = 1'b1;
                w_pcsrc    = 2'b01;
                w_aluop    = ((op == OP_REGIMM) && (rt != 5'd0)) ? 4'b1001 : 4'b0001;
                w_pc_en    = w_taken;
            end
            S_JUMP: begin
                w_pc_en = 1'b1;
                w_pcsrc = 2'b10;
            end
            S_IMM_EX: begin
                w_alusrc_a = 1'b1;
                w_alusrc_b = 2'b10;
                case (op)
                    OP_ANDI: w_aluop = 4'b0010;
                    OP_ORI:  w_aluop = 4'b0011;
                    default: w_aluop = 4'b0000;
                endcase
            end
            S_IMM_WB:   w_regwrite = 1'b1;
            S_JAL: begin
                w_regwrite = 1'b1;
                w_regdest  = 2'b10;
                w_memtoreg = 2'b10;
                w_pc_en    = 1'b1;
                w_pcsrc    = 2'b10;
            end
            S_JR: begin
                w_pc_en = 1'b1;
                w_pcsrc = 2'b11;
            end
            default: begin
                w_pc_en = 1'b0;
            end
        endcase
    end

    // Reset forces every output low immediately, independent of the clock.
    assign pc_en     = w_pc_en     & ~reset;
    assign iord      = w_iord      & ~reset;
    assign mem_read  = w_mem_read  & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign regwrite  = w_regwrite  & ~reset;
    assign alusrc_a  = w_alusrc_a  & ~reset;
    assign regdest   = reset ? 2'b00 : w_regdest;
    assign memtoreg  = reset ? 2'b00 : w_memtoreg;
    assign alusrc_b  = reset ? 2'b00 : w_alusrc_b;
    assign pcsrc     = reset ? 2'b00 : w_pcsrc;
    assign aluop     = reset ? '0 : ALUOPW'(w_aluop);
    assign state     = reset ? 4'd0 : r_state;
    assign trap      = ~reset & (r_state == S_TRAP);

`ifdef MC_CONTROL_RETIRE_CNT_EN
    logic [31:0] r_retired;

    // Count every return to FETCH from another state as one retired instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if ((r_state != S_FETCH) && (w_next == S_FETCH)) begin
            r_retired <= r_retired + 32'd1;
        end else begin
            r_retired <= r_retired;
        end
    end

    assign retired = r_retired;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle main control unit for the MIPS core. Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives datapath enables and muxes one state per cycle. Supports wait states on a memory ready handshake with a bounded timeout. Keeps the combinational decoder's opcode set, mux codes and 4-bit ALU-op encoding, and adds illegal-opcode trapping.

Parameters:
MAX_WAIT, 15, max consecutive cycles waiting on mem_ready before trapping; 0 disables the timeout.
ALUOPW, 4, ALU-op output width; must be at least 4, upper bits driven 0.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
op  in  6  opcode from instruction register, stable from DECODE onward
funct  in  6  funct field from IR
rt  in  5  rt field from IR
mem_ready  in  1  memory completes the current access this cycle
alu_zero  in  1  ALU result == 0
alu_neg  in  1  ALU result sign bit
pc_en  out  1  PC write enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
regdest  out  2  00 rt, 01 rd, 10 r31
memtoreg  out  2  00 ALUOut, 01 MDR, 10 PC
regwrite  out  1  register file write
alusrc_a  out  1  0 PC, 1 rs
alusrc_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
aluop  out  ALUOPW  ALU operation code
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
state  out  4  current state, for debug
trap  out  1  sticky fault flag
retired  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset: state = FETCH, wait counter = 0, trap = 0. While reset is high, pc_en, ir_write, regwrite, mem_read and mem_write are 0; all other outputs are 0.
- Enables are Moore outputs of state, except these, which are gated by mem_ready or the ALU flags:
  - FETCH: pc_en and ir_write
  - BRANCH: pc_en
- ALU-op codes: add 0000; branch subtract 0001; andi 0010; ori 0011; R-type 0110; bgez/bltz with rt != 0 use 1001.
- States and outputs:
  - FETCH (0): mem_read = 1, iord = 0, alusrc_a = 0, alusrc_b = 01, aluop = 0000, pcsrc = 00. When mem_ready = 1: pc_en = 1, ir_write = 1, go to DECODE. Otherwise stay.
  - DECODE (1): alusrc_a = 0, alusrc_b = 11, aluop = 0000 (branch target into ALUOut). Dispatch on op:
    - lw (0x23) / sw (0x2B) -> MEMADR
    - op 0x00 with funct 0x08 -> JR; other op 0x00 -> RTYPE_EX
    - beq 0x04, bne 0x05, blez 0x06, bgtz 0x07, op 0x01 -> BRANCH
    - j 0x02 -> JUMP
    - jal 0x03 -> JAL
    - addi 0x08, andi 0x0C, ori 0x0D -> IMM_EX
    - anything else -> TRAP
  - MEMADR (2): alusrc_a = 1, alusrc_b = 10, aluop = 0000. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD (3): mem_read = 1, iord = 1. On mem_ready -> MEMWB.
  - MEMWB (4): regwrite = 1, regdest = 00, memtoreg = 01 -> FETCH.
  - MEMWR (5): mem_write = 1, iord = 1. On mem_ready -> FETCH.
  - RTYPE_EX (6): alusrc_a = 1, alusrc_b = 00, aluop = 0110 -> RTYPE_WB.
  - RTYPE_WB (7): regwrite = 1, regdest = 01, memtoreg = 00 -> FETCH.
  - BRANCH (8): alusrc_a = 1, alusrc_b = 00, pcsrc = 01. aluop = 0001, or 1001 for op 0x01 with rt != 0.
    - pc_en = branch taken: beq zero; bne !zero; blez neg|zero; bgtz !neg&!zero; op 0x01 rt == 0 (bltz) neg; op 0x01 rt != 0 (bgez) !neg.
    - Next state FETCH.
  - JUMP (9): pc_en = 1, pcsrc = 10 -> FETCH.
  - IMM_EX (10): alusrc_a = 1, alusrc_b = 10. aluop = 0000 addi, 0010 andi, 0011 ori -> IMM_WB.
  - IMM_WB (11): regwrite = 1, regdest = 00, memtoreg = 00 -> FETCH.
  - JAL (12): regwrite = 1, regdest = 10, memtoreg = 10, pc_en = 1, pcsrc = 10 -> FETCH.
  - JR (13): pc_en = 1, pcsrc = 11, regwrite = 0 -> FETCH.
  - TRAP (14): all enables 0, trap = 1. Held until reset.
- Latency: R-type, immediate and load-address paths take 4 cycles with zero wait states; lw takes 5; sw 4; branch, j, jal and jr take 3.
- Wait counter:
  - Counts cycles in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Cleared on mem_ready = 1 and on any state change.
  - If MAX_WAIT > 0 and the counter equals MAX_WAIT while mem_ready = 0, next state is TRAP.
  - mem_ready in the same cycle as the limit wins: normal progress, no trap.
- Reset mid-instruction: state returns immediately to FETCH, and no enable is asserted after reset rises.

Optional Feature:
MC_CONTROL_RETIRE_CNT_EN.
- Defined: retired is a 32-bit counter, reset to 0, incremented on each transition into FETCH from any non-FETCH state; it wraps modulo 2^32.
- Undefined: retired is tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset, then op = 0x00, funct = 0x20, mem_ready = 1 constantly -> state 0,1,6,7,0. RTYPE_WB shows regwrite = 1, regdest = 01; aluop = 0110 in RTYPE_EX.
- lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read = 1, iord = 1, then MEMWB with memtoreg = 01. No trap.
- Branch op = 0x01, rt = 1, alu_neg = 0 -> BRANCH aluop = 1001, pc_en = 1, pcsrc = 01. Same with alu_neg = 1 -> pc_en = 0.
- jal -> JAL: regdest = 10, memtoreg = 10, pc_en = 1, pcsrc = 10. jr (op 0, funct 0x08) -> pc_en = 1, pcsrc = 11, regwrite = 0.
- op = 0x3F -> TRAP after DECODE, trap = 1 held 20 cycles. Reset -> FETCH, trap = 0.
- MAX_WAIT = 15, mem_ready = 0 in FETCH -> TRAP entered on cycle 16. With MC_CONTROL_RETIRE_CNT_EN, retired = 3 after three completed instructions.
